// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: two requester channels, pipeline hold and the
// registered register-file write port driven by the arbiter.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              hold;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              mux_sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              collide;

    modport master (
        output hold,
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  mux_sel, wr_en, wr_addr, wr_data, collide
    );

    modport slave (
        input  hold,
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output mux_sel, wr_en, wr_addr, wr_data, collide
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU vs load).
// Optional macro WB_COLLIDE_EN: same-address collisions drop the ALU write.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    logic              last_grant_q, last_grant_d;
    logic              mux_sel_q, mux_sel_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              blocked;
    logic              coll;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;

    always_comb begin
        blocked = rst | bus.hold;
`ifdef WB_COLLIDE_EN
        coll = !blocked && bus.req0_valid && bus.req1_valid &&
               (bus.req0_addr == bus.req1_addr) && (bus.req0_addr != '0);
`else
        coll = 1'b0;
`endif
        // Tie goes to the source that did not win last time.
        grant0 = !blocked && bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1 = !blocked && bus.req1_valid && (!bus.req0_valid || !last_grant_q || coll);
        accept = grant0 | grant1;
        win_addr = grant1 ? bus.req1_addr : bus.req0_addr;
    end

    // A collision consumes source 0 too, but only source 1 is written.
    assign bus.req0_ready = grant0 | coll;
    assign bus.req1_ready = grant1;

    always_comb begin
        last_grant_d = last_grant_q;
        mux_sel_d    = mux_sel_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        if (accept) begin
            last_grant_d = grant1;
            mux_sel_d    = grant1;
            wr_addr_d    = win_addr;
            wr_data_d    = grant1 ? bus.req1_data : bus.req0_data;
            wr_en_d      = (win_addr != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            mux_sel_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            mux_sel_q    <= mux_sel_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.mux_sel = mux_sel_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

`ifdef WB_COLLIDE_EN
    logic collide_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            collide_q <= 1'b0;
        end else begin
            collide_q <= coll;
        end
    end

    assign bus.collide = collide_q;
`else
    assign bus.collide = 1'b0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter against a rule-level
// model of the grant policy and the registered write port.
module tb_wb_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef WB_COLLIDE_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: current and next-cycle visible state.
    bit          m_lg, m_sel, m_en, m_coll;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit          n_lg, n_sel, n_en, n_coll;
    logic [AW-1:0] n_addr;
    logic [DW-1:0] n_data;
    bit          e_r0, e_r1, e_cl;

    task automatic model_eval();
        bit v0, v1, win;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        e_r0 = 0; e_r1 = 0; e_cl = 0;
        if (!rst && !bus.hold) begin
            if (COLL && v0 && v1 && bus.req0_addr == bus.req1_addr && bus.req0_addr != 0) begin
                e_r0 = 1; e_r1 = 1; e_cl = 1;
            end else if (v0 && v1) begin
                if (m_lg) e_r0 = 1; else e_r1 = 1;
            end else if (v0) begin
                e_r0 = 1;
            end else if (v1) begin
                e_r1 = 1;
            end
        end
        n_lg = m_lg; n_sel = m_sel; n_addr = m_addr; n_data = m_data;
        n_en = 0; n_coll = 0;
        if (rst) begin
            n_lg = 1; n_sel = 0; n_addr = 0; n_data = 0;
        end else if (e_r0 || e_r1) begin
            win    = e_r1;
            n_lg   = win;
            n_sel  = win;
            n_addr = win ? bus.req1_addr : bus.req0_addr;
            n_data = win ? bus.req1_data : bus.req0_data;
            n_en   = (n_addr != 0);
            n_coll = e_cl;
        end
    endtask

    // One clock: inputs already driven after negedge.
    task automatic step();
        #1;
        model_eval();
        check("req0_ready", bus.req0_ready, e_r0);
        check("req1_ready", bus.req1_ready, e_r1);
        @(posedge clk);
        m_lg = n_lg; m_sel = n_sel; m_en = n_en; m_coll = n_coll;
        m_addr = n_addr; m_data = n_data;
        @(negedge clk);
        check("wr_en", bus.wr_en, m_en);
        check("mux_sel", bus.mux_sel, m_sel);
        check("wr_addr", bus.wr_addr, m_addr);
        check("wr_data", bus.wr_data, m_data);
        check("collide", bus.collide, m_coll);
        if (e_r0 || e_r1)
            $display("XFER r0=%0d r1=%0d sel=%0d addr=%0d data=%08h wr_en=%0d collide=%0d",
                     e_r0, e_r1, m_sel, m_addr, m_data, m_en, m_coll);
        if (e_r0) bus.req0_valid = 1'b0;
        if (e_r1) bus.req1_valid = 1'b0;
    endtask

    task automatic set0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d;
    endtask

    task automatic set1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        m_lg = 1; m_sel = 0; m_en = 0; m_coll = 0; m_addr = 0; m_data = 0;
        rst = 1'b1;
        bus.hold = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        @(negedge clk);
        do_reset();
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_mux_sel", bus.mux_sel, 0);
        check("rst_collide", bus.collide, 0);

        // Single ALU write
        set0(5'd3, 32'h0000_00AA);
        step();
        check("tp1_wr_en", bus.wr_en, 1);
        check("tp1_wr_addr", bus.wr_addr, 3);
        check("tp1_wr_data", bus.wr_data, 32'hAA);
        check("tp1_mux_sel", bus.mux_sel, 0);

        // Alternation from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (!bus.req0_valid) set0(5'd4, $urandom);
            if (!bus.req1_valid) set1(5'd5, $urandom);
            #1;
            check("tp2_grant0", bus.req0_ready, (i % 2) == 0);
            step();
            check("tp2_sel", bus.mux_sel, (i % 2) == 1);
            check("tp2_wr_en", bus.wr_en, 1);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step();

        // Write to r0 is consumed and discarded
        set1(5'd0, 32'hFFFF_FFFF);
        step();
        check("tp3_wr_en", bus.wr_en, 0);
        check("tp3_mux_sel", bus.mux_sel, 1);

        // Hold keeps priority (last grant is 1, so source 0 goes first)
        set0(5'd8, 32'h1234_5678);
        set1(5'd9, 32'h9ABC_DEF0);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("tp4_hold_wr_en", bus.wr_en, 0);
        end
        bus.hold = 1'b0;
        #1;
        check("tp4_first_grant0", bus.req0_ready, 1);
        step();
        step();
        check("tp4_second_sel", bus.mux_sel, 1);

        // Reset after a source-1 grant while both valid
        set0(5'd10, $urandom);
        set1(5'd11, $urandom);
        rst = 1'b1;
        #1;
        check("tp5_rst_ready0", bus.req0_ready, 0);
        check("tp5_rst_ready1", bus.req1_ready, 0);
        step();
        check("tp5_rst_wr_en", bus.wr_en, 0);
        check("tp5_rst_addr", bus.wr_addr, 0);
        rst = 1'b0;
        #1;
        check("tp5_after_grant0", bus.req0_ready, 1);
        step();
        step();

        // Same-address pair
        do_reset();
        set0(5'd7, 32'h11);
        set1(5'd7, 32'h22);
        step();
        check("tp6_first_data", bus.wr_data, COLL ? 32'h22 : 32'h11);
        check("tp6_first_collide", bus.collide, COLL);
        check("tp6_first_en", bus.wr_en, 1);
        step();
        check("tp6_second_en", bus.wr_en, !COLL);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            bus.hold = ($urandom_range(0, 7) == 0);
            if (!bus.req0_valid && $urandom_range(0, 1) == 1)
                set0(5'($urandom_range(0, 7)), $urandom);
            if (!bus.req1_valid && $urandom_range(0, 1) == 1)
                set1(5'($urandom_range(0, 7)), $urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback requesters: source 0 = ALU result, source 1 = load data.
- Drives the select of the 5-bit write-address 2:1 mux, plus the write enable, address and data registers.
- Sits between the execute/memory stages and the register file.
- Round-robin grant, valid/ready handshake, one registered output stage.

Parameters:
- DATA_W, 32, width of writeback data.
- ADDR_W, 5, register address width; register 0 is hard-wired zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  pipeline stall; blocks all grants while high.
- req0_valid  in  1  source 0 has a write pending.
- req0_addr  in  ADDR_W  source 0 destination register.
- req0_data  in  DATA_W  source 0 write data.
- req0_ready  out  1  source 0 accepted this cycle.
- req1_valid  in  1  source 1 has a write pending.
- req1_addr  in  ADDR_W  source 1 destination register.
- req1_data  in  DATA_W  source 1 write data.
- req1_ready  out  1  source 1 accepted this cycle.
- mux_sel  out  1  write-address mux select: 0 selects source 0 address, 1 selects source 1.
- wr_en  out  1  register-file write enable.
- wr_addr  out  ADDR_W  register-file write address.
- wr_data  out  DATA_W  register-file write data.
- collide  out  1  same-address drop pulse; only present with the optional feature, otherwise tied 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: mux_sel=0, wr_en=0, wr_addr=0, wr_data=0, collide=0, last_grant=1. With last_grant=1, source 0 wins the first tie.
- Transfer rule: a transfer occurs when reqN_valid & reqN_ready at a rising edge. Requesters hold valid, addr and data stable until accepted.
- Ready timing: ready is combinational from valid, hold, rst and last_grant. It never depends on any output register.
- Grant (combinational, at most one per cycle):
  - rst=1 or hold=1: both ready=0.
  - Only one source valid: that source gets ready=1.
  - Both valid: the source not equal to last_grant gets ready=1.
  - Neither valid: both ready=0.
- State update on an accepted transfer:
  - last_grant <= granted index.
  - mux_sel <= granted index.
  - wr_addr <= granted addr; wr_data <= granted data.
  - wr_en <= 1 if granted addr != 0, else 0. A write to register 0 is consumed and discarded.
- No transfer in a cycle: wr_en <= 0. mux_sel, wr_addr, wr_data and last_grant hold.
- Latency: exactly 1 cycle from acceptance edge to wr_en visible. Throughput is 1 write per cycle.
- Fairness: with both sources continuously valid and hold=0, grants alternate 0,1,0,1… No source waits more than 1 cycle once hold is low.
- Hold: hold=1 mid-stream blocks grants, forces wr_en=0 the next cycle and keeps last_grant. Arbitration resumes from the same priority when hold drops.
- Reset mid-operation: rst=1 blocks acceptance that cycle. All registers take reset values at the edge. Pending requests stay valid and are arbitrated after rst falls.
- Ordering: when both sources stay valid, the ungranted request is granted in the following cycle. Writes to the same address therefore land in grant order, and the later write wins.

Optional Feature:
- Macro: WB_COLLIDE_EN.
- Defined: a same-address collision is when both sources are valid in the same cycle with req0_addr == req1_addr != 0 and hold=0. On a collision:
  - Source 1 is granted.
  - Source 0 is also given ready=1 and consumed, but its write is dropped.
  - collide=1 for one cycle, aligned with wr_en.
  - last_grant <= 1.
- Not defined: collide is tied 0 and normal round-robin applies, so both writes occur in consecutive cycles.

Test Plan:
- Reset, then req0 only: addr=3, data=0x0000_00AA, hold=0. Response: req0_ready=1; next cycle wr_en=1, wr_addr=3, wr_data=0xAA, mux_sel=0.
- Both valid from reset for 4 cycles: req0 addr=4, req1 addr=5. Response: grants 0,1,0,1; mux_sel follows each grant one cycle later; wr_en=1 every cycle.
- req1 addr=0, data=0xFFFF_FFFF. Response: req1_ready=1; next cycle wr_en=0, mux_sel=1, last_grant=1.
- Both valid, hold=1 for 3 cycles, then hold=0. Response: ready=0 and wr_en=0 throughout hold; the first grant after release follows last_grant saved before hold.
- rst asserted for 1 cycle while both valid after a source-1 grant. Response: no acceptance that cycle; outputs zero; source 0 granted first after reset.
- With WB_COLLIDE_EN: both valid, addr=7, data0=0x11, data1=0x22. Response: both ready=1; next cycle wr_en=1, wr_addr=7, wr_data=0x22, mux_sel=1, collide=1. Without the macro: 0x11 is written then 0x22, and collide stays 0.
